// File: rtl/gf180mcu_osu_sc_gp12t3v3__latbank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gf180mcu_osu_sc_gp12t3v3__latbank_ctrl                                   |
// | Arbitrated write controller for a negative-transparent latch bank.       |
// | Optional macro: LATBANK_CTRL_FIXED_PRIO_EN (fixed-priority arbitration). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gf180mcu_osu_sc_gp12t3v3__latbank_ctrl #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*DW-1:0] DIN,
  output logic [NREQ-1:0]    GNT,
  output logic [DW-1:0]      WDATA,
  output logic [(2**AW)-1:0] LEN_N,
  output logic               BUSY,
  output logic               DONE
);

  localparam int c_NENT = 2**AW;
  localparam int c_PW   = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_capture;
  logic [c_PW-1:0]     w_winner;
  logic [AW-1:0]       w_win_addr;
  logic [DW-1:0]       w_win_data;

  logic [NREQ-1:0]     r_gnt;
  logic [DW-1:0]       r_wdata;
  logic [c_NENT-1:0]   r_len_n;
  logic                r_busy;
  logic                r_done;
  logic [AW-1:0]       r_addr;
`ifndef LATBANK_CTRL_FIXED_PRIO_EN
  logic [c_PW-1:0]     r_ptr;
`endif

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE, CLOSE: begin
        if (|REQ) begin
          w_next    = SETUP;
          w_capture = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      SETUP:   w_next = OPEN;
      OPEN:    w_next = CLOSE;
      default: w_next = IDLE;
    endcase
  end

  // Descending scans let the lowest qualifying index overwrite last.
  always_comb begin
    w_winner   = '0;
    w_win_addr = '0;
    w_win_data = '0;
`ifdef LATBANK_CTRL_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        w_winner   = c_PW'(i);
        w_win_addr = ADDR[i*AW +: AW];
        w_win_data = DIN[i*DW +: DW];
      end
    end
`else
    // Wrapped candidates (below ptr) first, so any candidate at/above ptr wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i] && (i < int'(r_ptr))) begin
        w_winner   = c_PW'(i);
        w_win_addr = ADDR[i*AW +: AW];
        w_win_data = DIN[i*DW +: DW];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i] && (i >= int'(r_ptr))) begin
        w_winner   = c_PW'(i);
        w_win_addr = ADDR[i*AW +: AW];
        w_win_data = DIN[i*DW +: DW];
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_wdata <= '0;
      r_len_n <= '1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
`ifndef LATBANK_CTRL_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == CLOSE);
      r_gnt   <= w_capture ? (NREQ'(1) << w_winner) : '0;
      // Enable opens one cycle after data is launched and closes one cycle before data may move.
      r_len_n <= (w_next == OPEN) ? ~(c_NENT'(1) << r_addr) : '1;
      if (w_capture) begin
        r_addr  <= w_win_addr;
        r_wdata <= w_win_data;
`ifndef LATBANK_CTRL_FIXED_PRIO_EN
        r_ptr   <= (w_winner == c_PW'(NREQ - 1)) ? '0 : w_winner + c_PW'(1);
`endif
      end
    end
  end

  assign GNT   = r_gnt;
  assign WDATA = r_wdata;
  assign LEN_N = r_len_n;
  assign BUSY  = r_busy;
  assign DONE  = r_done;

endmodule
`default_nettype wire
